// File: rtl/write_buffer_controller.sv
// Store-path write buffer: queues CPU word writes for main memory, updates the cache
// on write hits and forwards still-buffered data to the read path.
module write_buffer_controller #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_req,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       wr_ready,
    input  logic                       cache_hit,
    output logic                       cache_wr_en,
    output logic [ADDR_W-1:0]          cache_wr_addr,
    output logic [DATA_W-1:0]          cache_wr_data,
    output logic                       mem_wr_en,
    output logic [ADDR_W-1:0]          mem_wr_addr,
    output logic [DATA_W-1:0]          mem_wr_data,
    input  logic                       mem_ack,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic                       fwd_hit,
    output logic [DATA_W-1:0]          fwd_data,
    output logic [$clog2(DEPTH+1)-1:0] buf_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WRITE   = 2'd1,
        S_RECOVER = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ADDR_W-1:0] r_addr_q [DEPTH];
    logic [DATA_W-1:0] r_data_q [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_push;
    logic              w_pop;

    logic              r_cache_vld_p1;
    logic [ADDR_W-1:0] r_cache_addr_p1;
    logic [DATA_W-1:0] r_cache_data_p1;

    logic              w_fwd_hit;
    logic [DATA_W-1:0] w_fwd_data;
    logic [PTR_W-1:0]  w_fwd_idx;

    // Full is judged on the registered count, so a pop in the same cycle never
    // frees a slot early.
    assign wr_ready  = (r_count != CNT_W'(DEPTH));
    assign w_push    = wr_req && wr_ready;
    assign buf_count = r_count;

    // FIFO control: pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr_q[r_wptr] <= wr_addr;
            r_data_q[r_wptr] <= wr_data;
        end
    end

    // p0 -> p1: cache write-through strobe, one cycle after the accepting edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cache_vld_p1 <= 1'b0;
        end else begin
            r_cache_vld_p1 <= w_push && cache_hit;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && cache_hit) begin
            r_cache_addr_p1 <= wr_addr;
            r_cache_data_p1 <= wr_data;
        end
    end

    assign cache_wr_en   = r_cache_vld_p1;
    assign cache_wr_addr = r_cache_vld_p1 ? r_cache_addr_p1 : '0;
    assign cache_wr_data = r_cache_vld_p1 ? r_cache_data_p1 : '0;

    // Drain FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        mem_wr_en   = 1'b0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                mem_wr_en   = 1'b1;
                mem_wr_addr = r_addr_q[r_rptr];
                mem_wr_data = r_data_q[r_rptr];
                if (mem_ack) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_RECOVER;
                end
            end
            S_RECOVER: begin
                w_state_nxt = (r_count != '0) ? S_WRITE : S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Forwarding scans oldest to youngest so the last match (youngest) wins.
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        w_fwd_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_fwd_idx = r_rptr + PTR_W'(k);
            if ((CNT_W'(k) < r_count) && (r_addr_q[w_fwd_idx] == rd_addr)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_data_q[w_fwd_idx];
            end
        end
    end

    assign fwd_hit  = w_fwd_hit;
    assign fwd_data = w_fwd_data;

endmodule

// File: tb/tb_write_buffer_controller.sv
// Scoreboard bench for write_buffer_controller: a queue-based reference model predicts
// buffer contents, drain timing and forwarding; a separate monitor checks cache/memory writes.
module tb_write_buffer_controller;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 15;
    localparam int DATA_W = 32;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              cache_hit;
    logic              cache_wr_en;
    logic [ADDR_W-1:0] cache_wr_addr;
    logic [DATA_W-1:0] cache_wr_data;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic              mem_ack;
    logic [ADDR_W-1:0] rd_addr;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic [CNT_W-1:0]  buf_count;

    always #5 clk = ~clk;

    write_buffer_controller #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .cache_hit(cache_hit), .cache_wr_en(cache_wr_en),
        .cache_wr_addr(cache_wr_addr), .cache_wr_data(cache_wr_data),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_ack(mem_ack), .rd_addr(rd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .buf_count(buf_count)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } ent_t;

    typedef struct {
        int                cyc;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cwr_t;

    ent_t model_q[$];
    ent_t exp_mem[$];
    cwr_t exp_cache[$];

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    bit   armed = 0;
    int   prev_cnt = 0;
    bit   prev_hs = 0;

    bit                m_en;
    bit                m_hs;
    bit                m_acc;
    bit                m_fh;
    logic [DATA_W-1:0] m_fd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // Reference model: sees the inputs of each cycle at the falling edge, checks the
    // visible state, then applies the accept/drain rules for the coming rising edge.
    initial begin : model
        forever begin
            @(negedge clk);
            if (!armed) begin
                if (rst) begin
                    armed    = 1;
                    prev_cnt = 0;
                    prev_hs  = 0;
                end
            end else begin
                m_en = (prev_cnt != 0) && !prev_hs;
                chk("wr_ready", 32'(wr_ready), 32'(model_q.size() != DEPTH));
                chk("buf_count", 32'(buf_count), 32'(model_q.size()));
                chk("mem_wr_en", 32'(mem_wr_en), 32'(m_en));
                if (m_en && model_q.size() != 0) begin
                    chk("mem_wr_addr", 32'(mem_wr_addr), 32'(model_q[0].addr));
                    chk("mem_wr_data", mem_wr_data, model_q[0].data);
                end
                m_fh = 0;
                m_fd = '0;
                foreach (model_q[i]) begin
                    if (model_q[i].addr == rd_addr) begin
                        m_fh = 1;
                        m_fd = model_q[i].data;
                    end
                end
                chk("fwd_hit", 32'(fwd_hit), 32'(m_fh));
                if (m_fh) chk("fwd_data", fwd_data, m_fd);

                m_hs  = m_en && mem_ack;
                m_acc = wr_req && (model_q.size() != DEPTH);
                if (rst) begin
                    model_q.delete();
                    exp_mem.delete();
                    exp_cache.delete();
                    prev_cnt = 0;
                    prev_hs  = 0;
                end else begin
                    prev_cnt = model_q.size();
                    prev_hs  = m_hs;
                    if (m_hs) void'(model_q.pop_front());
                    if (m_acc) begin
                        model_q.push_back('{addr: wr_addr, data: wr_data});
                        exp_mem.push_back('{addr: wr_addr, data: wr_data});
                        if (cache_hit)
                            exp_cache.push_back('{cyc: cyc + 1, addr: wr_addr, data: wr_data});
                    end
                end
            end
            cyc++;
        end
    end

    // Monitor: consumes expected cache updates and memory writes as the DUT emits them.
    initial begin : monitor
        forever begin
            @(posedge clk);
            #3;
            if (armed) begin
                if (exp_cache.size() != 0 && exp_cache[0].cyc == cyc) begin
                    chk("cache_wr_en", 32'(cache_wr_en), 32'(1));
                    chk("cache_wr_addr", 32'(cache_wr_addr), 32'(exp_cache[0].addr));
                    chk("cache_wr_data", cache_wr_data, exp_cache[0].data);
                    void'(exp_cache.pop_front());
                end else begin
                    chk("cache_wr_en idle", 32'(cache_wr_en), 32'(0));
                end
                if (mem_wr_en && mem_ack) begin
                    if (exp_mem.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL mem_write: got unexpected write addr 0x%0h, want none", mem_wr_addr);
                    end else begin
                        chk("drain addr", 32'(mem_wr_addr), 32'(exp_mem[0].addr));
                        chk("drain data", mem_wr_data, exp_mem[0].data);
                        void'(exp_mem.pop_front());
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    task automatic cpu_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic hit);
        bit ok;
        ok        = 0;
        wr_req    = 1'b1;
        wr_addr   = a;
        wr_data   = d;
        cache_hit = hit;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = wr_ready;
            tick();
        end
        wr_req = 1'b0;
        if (!ok) fail_now("cpu_write accept");
    endtask

    task automatic wait_mem_en(input int maxc);
        bit seen;
        seen = 0;
        for (int i = 0; i < maxc && !seen; i++) begin
            @(negedge clk);
            seen = mem_wr_en;
        end
        if (!seen) fail_now("wait mem_wr_en");
        tick();
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        rst       = 1'b1;
        wr_req    = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        cache_hit = 1'b0;
        mem_ack   = 1'b0;
        rd_addr   = '0;
        repeat (2) tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("reset wr_ready", 32'(wr_ready), 32'(1));
        chk("reset buf_count", 32'(buf_count), 32'(0));
        chk("reset mem_wr_en", 32'(mem_wr_en), 32'(0));
        chk("reset cache_wr_en", 32'(cache_wr_en), 32'(0));
        tick();

        // Single hit write: cache strobe next cycle, memory write two cycles after accept
        cpu_write(15'h0400, 32'hDEADBEEF, 1'b1);
        @(negedge clk);
        chk("t2 cache strobe", 32'(cache_wr_en), 32'(1));
        chk("t2 mem early", 32'(mem_wr_en), 32'(0));
        tick();
        @(negedge clk);
        chk("t2 mem_wr_en", 32'(mem_wr_en), 32'(1));
        chk("t2 mem_wr_addr", 32'(mem_wr_addr), 32'h0400);
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        @(negedge clk);
        chk("t2 count after ack", 32'(buf_count), 32'(0));
        chk("t2 recover", 32'(mem_wr_en), 32'(0));
        tick();
        repeat (2) tick();

        // Fill with no acks, then one ack frees a slot for the fifth write
        for (int i = 0; i < 4; i++) cpu_write(ADDR_W'(15'h0200 + i), 32'hA000_0000 + 32'(i), 1'(i % 2));
        repeat (2) tick();
        @(negedge clk);
        chk("t3 full count", 32'(buf_count), 32'(4));
        chk("t3 full ready", 32'(wr_ready), 32'(0));
        tick();
        mem_ack = 1'b1;
        fork
            cpu_write(15'h0204, 32'hA000_0004, 1'b0);
            begin
                tick();
                mem_ack = 1'b0;
            end
        join
        mem_ack = 1'b1;
        repeat (14) tick();
        mem_ack = 1'b0;
        tick();

        // Forwarding: youngest of two same-address entries wins
        do_reset(1);
        cpu_write(15'h0800, 32'h0000_0011, 1'b0);
        cpu_write(15'h0800, 32'h0000_0022, 1'b1);
        rd_addr = 15'h0800;
        @(negedge clk);
        chk("t4 fwd_hit", 32'(fwd_hit), 32'(1));
        chk("t4 fwd_data", fwd_data, 32'h0000_0022);
        tick();
        rd_addr = 15'h0801;
        @(negedge clk);
        chk("t4 fwd miss", 32'(fwd_hit), 32'(0));
        tick();

        // Push and pop in the same cycle at count 2, then pointer wrap
        do_reset(1);
        cpu_write(15'h0300, 32'h3000_0000, 1'b0);
        cpu_write(15'h0301, 32'h3000_0001, 1'b0);
        wait_mem_en(10);
        wr_req    = 1'b1;
        wr_addr   = 15'h0302;
        wr_data   = 32'h3000_0002;
        cache_hit = 1'b1;
        mem_ack   = 1'b1;
        tick();
        wr_req  = 1'b0;
        mem_ack = 1'b0;
        @(negedge clk);
        chk("t5 push+pop count", 32'(buf_count), 32'(2));
        tick();
        mem_ack = 1'b1;
        for (int i = 0; i < 9; i++) cpu_write(ADDR_W'(15'h0310 + i), $urandom, 1'($urandom_range(0, 1)));
        repeat (30) tick();
        mem_ack = 1'b0;

        // Reset while a memory write is outstanding; the late ack must be ignored
        do_reset(1);
        for (int i = 0; i < 3; i++) cpu_write(ADDR_W'(15'h0500 + i), $urandom, 1'b0);
        wait_mem_en(10);
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        mem_ack = 1'b1;
        @(negedge clk);
        chk("t6 count", 32'(buf_count), 32'(0));
        chk("t6 mem_wr_en", 32'(mem_wr_en), 32'(0));
        tick();
        repeat (3) tick();
        mem_ack = 1'b0;

        // Randomised traffic over a small address pool so forwarding hits often
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            wr_req    = ($urandom_range(0, 9) < 6);
            wr_addr   = ADDR_W'(15'h0100 + $urandom_range(0, 5));
            wr_data   = $urandom;
            cache_hit = 1'($urandom_range(0, 1));
            mem_ack   = ($urandom_range(0, 9) < 4);
            rd_addr   = ADDR_W'(15'h0100 + $urandom_range(0, 7));
            tick();
        end
        rst     = 1'b0;
        wr_req  = 1'b0;
        mem_ack = 1'b1;
        repeat (20) tick();
        if (exp_mem.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL final drain: got %0d writes outstanding, want 0", exp_mem.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
